grid_glyph_renderer: RTL and testbench
======================================

Name: grid_glyph_renderer

Overview:
- Parametrised successor to the chimp-test cell display.
- Holds a ROWS x COLS array of 4-bit cell values and renders the whole grid in one instance, rather than one instance per cell.
- Per-pixel RGB is produced through a 2-stage registered pipeline.
- Adds a write port, a clear, cursor blink, a seven-segment glyph set 0-9, and explicit out-of-grid handling.
- Sits between the game FSM and the VGA output mux.

Parameters:
- ROWS, 3, grid rows (1..8).
- COLS, 3, grid columns (1..8).
- CELL_W, 213, cell width in pixels.
- CELL_H, 160, cell height in pixels.
- GLYPH_MX, 75, left/right glyph margin inside the cell.
- GLYPH_MY, 16, top/bottom glyph margin inside the cell.
- STROKE, 20, segment and border thickness in pixels.
- BLINK_FRAMES, 30, frames per cursor blink half-period.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write the cell at wr_row/wr_col this cycle
- wr_row  in  RW=max(1,$clog2(ROWS))  write row
- wr_col  in  CW=max(1,$clog2(COLS))  write column
- wr_num  in  4  value 0..15; 0 means empty
- clr  in  1  zero all cells
- mode  in  3  1=SHOW, 2=MASKED, 3=WIN, 4=LOSE; others render black
- cur_row  in  RW  cursor row
- cur_col  in  CW  cursor column
- frame_tick  in  1  one-cycle pulse per frame
- x  in  10  pixel x
- y  in  10  pixel y
- video_on  in  1  active-area qualifier
- rgb  out  12  pixel colour
- rgb_valid  out  1  video_on delayed by 2 cycles

Behaviour:
- Reset values:
  - All cells = 0.
  - rgb = 12'h000, rgb_valid = 0.
  - Pipeline registers = 0.
  - blink counter = 0, blink_on = 1.
- Cell store:
  - Synchronous write at posedge clk.
  - clr has priority over wr_en in the same cycle.
  - Writes with wr_row >= ROWS or wr_col >= COLS are ignored.
- Stage 1, registered:
  - Cell column = first c with x < (c+1)*CELL_W; cell row is found the same way from y with CELL_H. Use comparator chains only, no dividers.
  - in_grid = (x < COLS*CELL_W) && (y < ROWS*CELL_H).
  - Local offsets lx = x - col*CELL_W, ly = y - row*CELL_H, both 10-bit.
  - Register col, row, lx, ly, in_grid, video_on and the selected cell value.
- Stage 2, registered:
  - Evaluate colour; rgb is valid 2 cycles after x/y.
  - If !video_on or !in_grid, output rgb = 0.
- Glyph box:
  - gx = lx - GLYPH_MX, gy = ly - GLYPH_MY.
  - GW = CELL_W - 2*GLYPH_MX, GH = CELL_H - 2*GLYPH_MY.
  - Inside-box test is strict: lx > GLYPH_MX && lx < CELL_W - GLYPH_MX, and likewise for y.
- Segments:
  - a: gy < STROKE.
  - d: gy >= GH - STROKE.
  - g: |gy - GH/2| < STROKE/2.
  - f/b: left/right columns of width STROKE, upper half (gy < GH/2).
  - e/c: left/right columns of width STROKE, lower half (gy >= GH/2).
  - Standard seven-segment map for 1..9; value 0 and values 10..15 draw no glyph.
- Mode SHOW:
  - Background 12'h000; cursor cell background 12'hF00.
  - Lit segments 12'hFFF, overriding the cursor background.
- Mode MASKED:
  - Cell value > 0 fills the whole cell 12'hFFF.
  - In the cursor cell, a border band of width STROKE is 12'hF00 while blink_on; otherwise the normal fill shows.
- Mode WIN: 12'h0F0 everywhere in-grid.
- Mode LOSE: 12'h000.
- Blink counter:
  - Increments on frame_tick.
  - At BLINK_FRAMES-1 it wraps to 0 and toggles blink_on.
  - Any change of cur_row/cur_col resets the counter to 0 and sets blink_on = 1.
- Mid-operation:
  - Mode and cursor are sampled at stage 2; no pipeline alignment is required for them.
  - A cell write is visible to any pixel whose stage 1 occurs on a later cycle.

Optional Feature:
- Macro: GRID_LINES_EN.
- Defined: in-grid pixels with lx==0 or ly==0 (excluding x==0/y==0) render 12'h444 in SHOW and MASKED modes, overriding all other colours.
- Undefined: no grid lines; logic is absent.

Decomposition:
- Package grid_glyph_pkg holds:
  - Mode localparams: MODE_SHOW=1, MODE_MASKED=2, MODE_WIN=3, MODE_LOSE=4.
  - Colour constants: COL_BG, COL_FG, COL_CURSOR, COL_WIN, COL_GRID.
  - The 10-entry seven-segment table as a function seg7(num) returning 7 bits.
- One sub-module, glyph_seg_hit: combinational; takes gx, gy and the segment mask, returns hit. Instanced in stage 2.

Test Plan:
- Reset then SHOW with all cells 0: scan x=0..639, y=0..479 -> rgb=0 everywhere except cursor cell (0,0) = 12'hF00; rgb_valid follows video_on with 2-cycle delay.
- Write (1,2)=8, mode SHOW, pixel (x=2*213+80, y=160+20) -> rgb=12'hFFF two cycles later (segment a); pixel (x=2*213+107, y=160+50) -> 12'h000.
- MASKED, cell (2,2)=5, cursor (2,2): pixel (430,325) -> 12'hF00 while blink_on; after 30 frame_ticks -> 12'hFFF; cursor move -> 12'hF00 immediately.
- clr and wr_en asserted together -> all cells 0; write to row 3 with ROWS=3 -> ignored, cell store unchanged.
- ROWS=4, COLS=5, CELL_W=128, CELL_H=120: pixel (639,479) in cell (3,4) renders; pixel beyond the grid with ROWS=2 -> 0. Mode 3 -> 12'h0F0; mode 6 -> 0.
- GRID_LINES_EN defined: pixel (213,100) in SHOW -> 12'h444; pixel (0,100) -> not grid colour.

Source files
------------

// File: rtl/grid_glyph_pkg.sv
// Shared modes, colours and the seven-segment table for the grid glyph renderer.
// Pure constants and one combinational helper; no latency, no flow control.
package grid_glyph_pkg;

    localparam logic [2:0] MODE_SHOW   = 3'd1;
    localparam logic [2:0] MODE_MASKED = 3'd2;
    localparam logic [2:0] MODE_WIN    = 3'd3;
    localparam logic [2:0] MODE_LOSE   = 3'd4;

    localparam logic [11:0] COL_BG     = 12'h000;
    localparam logic [11:0] COL_FG     = 12'hFFF;
    localparam logic [11:0] COL_CURSOR = 12'hF00;
    localparam logic [11:0] COL_WIN    = 12'h0F0;
    localparam logic [11:0] COL_GRID   = 12'h444;

    // Bit order is {g,f,e,d,c,b,a}; digit 0 and anything above 9 draw nothing.
    function automatic logic [6:0] seg7(input logic [3:0] num);
        case (num)
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

endpackage

// File: rtl/grid_glyph_renderer_seg_hit.sv
// Seven-segment hit test for one pixel at glyph-box offset (gx, gy).
// Combinational, zero latency; no flow control.
module glyph_seg_hit #(
    parameter int GW     = 63,
    parameter int GH     = 128,
    parameter int STROKE = 20
) (
    input  logic [9:0] gx,
    input  logic [9:0] gy,
    input  logic [6:0] seg_mask,
    output logic       hit
);

    logic       upper;
    logic       left;
    logic       right;
    logic [6:0] seg_geo;

    always_comb begin
        upper      = int'(gy) < GH / 2;
        left       = int'(gx) < STROKE;
        right      = int'(gx) >= GW - STROKE;
        seg_geo[0] = int'(gy) < STROKE;
        seg_geo[1] = right && upper;
        seg_geo[2] = right && !upper;
        seg_geo[3] = int'(gy) >= GH - STROKE;
        seg_geo[4] = left && !upper;
        seg_geo[5] = left && upper;
        // Centre bar: |gy - GH/2| < STROKE/2 without signed subtraction.
        seg_geo[6] = (int'(gy) + STROKE / 2 > GH / 2) && (int'(gy) < GH / 2 + STROKE / 2);
        hit        = |(seg_geo & seg_mask);
    end

endmodule

// File: rtl/grid_glyph_renderer.sv
// ROWS x COLS cell grid renderer: cell store, blink timer and 2-stage pixel pipe (GRID_LINES_EN adds grid lines).
// rgb/rgb_valid lag x/y/video_on by 2 cycles; one pixel per clock, no backpressure.
module grid_glyph_renderer
    import grid_glyph_pkg::*;
#(
    parameter int ROWS         = 3,
    parameter int COLS         = 3,
    parameter int CELL_W       = 213,
    parameter int CELL_H       = 160,
    parameter int GLYPH_MX     = 75,
    parameter int GLYPH_MY     = 16,
    parameter int STROKE       = 20,
    parameter int BLINK_FRAMES = 30,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [RW-1:0] wr_row,
    input  logic [CW-1:0] wr_col,
    input  logic [3:0]    wr_num,
    input  logic          clr,
    input  logic [2:0]    mode,
    input  logic [RW-1:0] cur_row,
    input  logic [CW-1:0] cur_col,
    input  logic          frame_tick,
    input  logic [9:0]    x,
    input  logic [9:0]    y,
    input  logic          video_on,
    output logic [11:0]   rgb,
    output logic          rgb_valid
);

    localparam int GW = CELL_W - 2 * GLYPH_MX;
    localparam int GH = CELL_H - 2 * GLYPH_MY;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [3:0]    cells [ROWS][COLS];

    logic [CW-1:0] col_c;
    logic [RW-1:0] row_c;
    logic [9:0]    col_base;
    logic [9:0]    row_base;
    logic          in_grid_c;

    logic [CW-1:0] s1_col;
    logic [RW-1:0] s1_row;
    logic [9:0]    s1_lx;
    logic [9:0]    s1_ly;
    logic          s1_in;
    logic          s1_vo;
    logic [3:0]    s1_num;

    logic [BW-1:0] blink_cnt;
    logic          blink_on;
    logic [RW-1:0] prev_row;
    logic [CW-1:0] prev_col;

    logic [9:0]    gx;
    logic [9:0]    gy;
    logic [6:0]    seg_mask;
    logic          seg_hit;
    logic          in_box;
    logic          is_cursor;
    logic          in_border;
    logic [11:0]   rgb_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    cells[r][c] <= 4'd0;
        end else if (clr) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    cells[r][c] <= 4'd0;
        end else if (wr_en && int'(wr_row) < ROWS && int'(wr_col) < COLS) begin
            cells[wr_row][wr_col] <= wr_num;
        end
    end

    // Descending scan so the lowest matching cell index wins; off-grid pixels land on the last cell.
    always_comb begin
        col_c    = CW'(COLS - 1);
        col_base = 10'((COLS - 1) * CELL_W);
        for (int c = COLS - 1; c >= 0; c--) begin
            if (int'(x) < (c + 1) * CELL_W) begin
                col_c    = CW'(c);
                col_base = 10'(c * CELL_W);
            end
        end
        row_c    = RW'(ROWS - 1);
        row_base = 10'((ROWS - 1) * CELL_H);
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (int'(y) < (r + 1) * CELL_H) begin
                row_c    = RW'(r);
                row_base = 10'(r * CELL_H);
            end
        end
        in_grid_c = (int'(x) < COLS * CELL_W) && (int'(y) < ROWS * CELL_H);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_col <= '0;
            s1_row <= '0;
            s1_lx  <= 10'd0;
            s1_ly  <= 10'd0;
            s1_in  <= 1'b0;
            s1_vo  <= 1'b0;
            s1_num <= 4'd0;
        end else begin
            s1_col <= col_c;
            s1_row <= row_c;
            s1_lx  <= x - col_base;
            s1_ly  <= y - row_base;
            s1_in  <= in_grid_c;
            s1_vo  <= video_on;
            s1_num <= cells[row_c][col_c];
        end
    end

    // A cursor move restarts the blink phase with the cursor visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
            prev_row  <= '0;
            prev_col  <= '0;
        end else begin
            prev_row <= cur_row;
            prev_col <= cur_col;
            if (cur_row != prev_row || cur_col != prev_col) begin
                blink_cnt <= '0;
                blink_on  <= 1'b1;
            end else if (frame_tick) begin
                if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                    blink_cnt <= '0;
                    blink_on  <= ~blink_on;
                end else begin
                    blink_cnt <= blink_cnt + BW'(1);
                end
            end
        end
    end

    assign gx       = s1_lx - 10'(GLYPH_MX);
    assign gy       = s1_ly - 10'(GLYPH_MY);
    assign seg_mask = seg7(s1_num);

    glyph_seg_hit #(
        .GW     (GW),
        .GH     (GH),
        .STROKE (STROKE)
    ) u_seg_hit (
        .gx       (gx),
        .gy       (gy),
        .seg_mask (seg_mask),
        .hit      (seg_hit)
    );

`ifdef GRID_LINES_EN
    logic grid_line;
    assign grid_line = (s1_lx == 10'd0 && s1_col != '0) || (s1_ly == 10'd0 && s1_row != '0);
`endif

    always_comb begin
        in_box    = int'(s1_lx) > GLYPH_MX && int'(s1_lx) < CELL_W - GLYPH_MX
                 && int'(s1_ly) > GLYPH_MY && int'(s1_ly) < CELL_H - GLYPH_MY;
        is_cursor = (s1_row == cur_row) && (s1_col == cur_col);
        in_border = int'(s1_lx) < STROKE || int'(s1_lx) >= CELL_W - STROKE
                 || int'(s1_ly) < STROKE || int'(s1_ly) >= CELL_H - STROKE;
        rgb_n     = COL_BG;
        if (s1_vo && s1_in) begin
            case (mode)
                MODE_SHOW: begin
                    if (in_box && seg_hit) rgb_n = COL_FG;
                    else if (is_cursor)    rgb_n = COL_CURSOR;
                end
                MODE_MASKED: begin
                    if (is_cursor && blink_on && in_border) rgb_n = COL_CURSOR;
                    else if (s1_num != 4'd0)                rgb_n = COL_FG;
                end
                MODE_WIN:  rgb_n = COL_WIN;
                default:   rgb_n = COL_BG;
            endcase
`ifdef GRID_LINES_EN
            if ((mode == MODE_SHOW || mode == MODE_MASKED) && grid_line)
                rgb_n = COL_GRID;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb       <= COL_BG;
            rgb_valid <= 1'b0;
        end else begin
            rgb       <= rgb_n;
            rgb_valid <= s1_vo;
        end
    end

endmodule

// File: tb/tb_grid_glyph_renderer.sv
// Randomised and directed checks of grid_glyph_renderer against a pixel-level reference model.
module tb_grid_glyph_renderer;

    localparam int ROWS = 3, COLS = 3, CELL_W = 213, CELL_H = 160;
    localparam int MX = 75, MY = 16, STROKE = 20, BF = 30;
    localparam int GW = CELL_W - 2 * MX, GH = CELL_H - 2 * MY;

    logic        clk = 0, rst_n = 0;
    logic        wr_en = 0, clr = 0, frame_tick = 0, video_on = 0;
    logic [1:0]  wr_row = 0, wr_col = 0, cur_row = 0, cur_col = 0;
    logic [3:0]  wr_num = 0;
    logic [2:0]  mode = 0;
    logic [9:0]  x = 0, y = 0;
    logic [11:0] rgb;
    logic        rgb_valid;

    int n_assert = 0, n_fail = 0;
    bit chk_en = 0;
    string digs [10] = '{"", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

    always #5 clk = ~clk;

    grid_glyph_renderer #(
        .ROWS(ROWS), .COLS(COLS), .CELL_W(CELL_W), .CELL_H(CELL_H),
        .GLYPH_MX(MX), .GLYPH_MY(MY), .STROKE(STROKE), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
        .wr_num(wr_num), .clr(clr), .mode(mode), .cur_row(cur_row), .cur_col(cur_col),
        .frame_tick(frame_tick), .x(x), .y(y), .video_on(video_on),
        .rgb(rgb), .rgb_valid(rgb_valid)
    );

    task automatic check(string name, logic [11:0] got, logic [11:0] want);
        n_assert++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, want, $time);
        end
    endtask

    function automatic bit seg_on(int num, byte s);
        string d = digs[num];
        for (int i = 0; i < d.len(); i++)
            if (d[i] == s) return 1;
        return 0;
    endfunction

    // Colour of one pixel straight from the geometric rules.
    function automatic logic [11:0] model_rgb(int px, int py, bit vo, int num, int md,
                                              int cr, int cc, bit blink);
        int col, row, lx, ly, gx, gy, dg;
        bit lit, cur, border, line;
        if (!vo || px >= COLS * CELL_W || py >= ROWS * CELL_H) return 12'h000;
        col = px / CELL_W;  row = py / CELL_H;
        lx  = px % CELL_W;  ly  = py % CELL_H;
        gx  = lx - MX;      gy  = ly - MY;
        dg  = (gy > GH / 2) ? gy - GH / 2 : GH / 2 - gy;
        lit = 0;
        if (lx > MX && lx < CELL_W - MX && ly > MY && ly < CELL_H - MY && num >= 1 && num <= 9) begin
            if (gy < STROKE && seg_on(num, "a")) lit = 1;
            if (gy >= GH - STROKE && seg_on(num, "d")) lit = 1;
            if (dg < STROKE / 2 && seg_on(num, "g")) lit = 1;
            if (gx < STROKE && gy < GH / 2 && seg_on(num, "f")) lit = 1;
            if (gx >= GW - STROKE && gy < GH / 2 && seg_on(num, "b")) lit = 1;
            if (gx < STROKE && gy >= GH / 2 && seg_on(num, "e")) lit = 1;
            if (gx >= GW - STROKE && gy >= GH / 2 && seg_on(num, "c")) lit = 1;
        end
        cur    = (row == cr) && (col == cc);
        border = lx < STROKE || lx >= CELL_W - STROKE || ly < STROKE || ly >= CELL_H - STROKE;
        line   = (lx == 0 && px != 0) || (ly == 0 && py != 0);
`ifdef GRID_LINES_EN
        if ((md == 1 || md == 2) && line) return 12'h444;
`else
        if (line && md == 99) return 12'h444;
`endif
        case (md)
            1: return lit ? 12'hFFF : (cur ? 12'hF00 : 12'h000);
            2: return (cur && blink && border) ? 12'hF00 : ((num > 0) ? 12'hFFF : 12'h000);
            3: return 12'h0F0;
            default: return 12'h000;
        endcase
    endfunction

    int m_cells [ROWS][COLS];
    int s1_x = 0, s1_y = 0, s1_num = 0, ticks = 0, prev_r = 0, prev_c = 0;
    bit s1_vo = 0, exp_vld = 0;
    logic [11:0] exp_rgb = 12'h000;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            foreach (m_cells[r, c]) m_cells[r][c] = 0;
            s1_x = 0; s1_y = 0; s1_num = 0; s1_vo = 0;
            ticks = 0; prev_r = 0; prev_c = 0;
            exp_rgb = 12'h000; exp_vld = 0;
        end else begin
            exp_rgb = model_rgb(s1_x, s1_y, s1_vo, s1_num, int'(mode), int'(cur_row),
                                int'(cur_col), ((ticks / BF) % 2) == 0);
            exp_vld = s1_vo;
            s1_x = int'(x); s1_y = int'(y); s1_vo = video_on;
            if (s1_x < COLS * CELL_W && s1_y < ROWS * CELL_H)
                s1_num = m_cells[s1_y / CELL_H][s1_x / CELL_W];
            else
                s1_num = 0;
            if (clr)
                foreach (m_cells[r, c]) m_cells[r][c] = 0;
            else if (wr_en && int'(wr_row) < ROWS && int'(wr_col) < COLS)
                m_cells[wr_row][wr_col] = int'(wr_num);
            if (int'(cur_row) != prev_r || int'(cur_col) != prev_c) ticks = 0;
            else if (frame_tick) ticks++;
            prev_r = int'(cur_row); prev_c = int'(cur_col);
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("rgb_vs_model", rgb, exp_rgb);
            check("rgb_valid_vs_model", {11'd0, rgb_valid}, {11'd0, exp_vld});
        end
    end

    task automatic write_cell(int r, int c, int v);
        @(negedge clk);
        wr_en = 1; wr_row = 2'(r); wr_col = 2'(c); wr_num = 4'(v);
        @(negedge clk);
        wr_en = 0;
    endtask

    task automatic lit_check(string name, int px, int py, bit vo, logic [11:0] want);
        @(negedge clk);
        x = 10'(px); y = 10'(py); video_on = vo;
        wr_en = 0; clr = 0; frame_tick = 0;
        @(negedge clk);
        @(negedge clk);
        check(name, rgb, want);
    endtask

    task automatic pulses(int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); frame_tick = 1;
            @(negedge clk); frame_tick = 0;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_rgb", rgb, 12'h000);
        check("reset_rgb_valid", {11'd0, rgb_valid}, 12'h000);
        rst_n = 1;
        chk_en = 1;
        mode = 3'd1;

        for (int yy = 0; yy < 480; yy += 8)
            for (int xx = 0; xx < 640; xx += 3) begin
                @(negedge clk);
                x = 10'(xx); y = 10'(yy); video_on = ($urandom_range(0, 7) != 0);
            end

        lit_check("show_empty_cursor", 100, 80, 1, 12'hF00);
        lit_check("show_empty_bg", 300, 80, 1, 12'h000);
        write_cell(1, 2, 8);
        lit_check("show_seg_a", 2 * 213 + 80, 160 + 20, 1, 12'hFFF);
        lit_check("show_glyph_gap", 2 * 213 + 107, 160 + 50, 1, 12'h000);
        lit_check("show_box_edge_out", 2 * 213 + 75, 160 + 20, 1, 12'h000);
        lit_check("show_box_edge_in", 2 * 213 + 76, 160 + 20, 1, 12'hFFF);
        cur_row = 1; cur_col = 2;
        lit_check("show_seg_over_cursor", 2 * 213 + 80, 160 + 20, 1, 12'hFFF);
        lit_check("show_cursor_gap", 2 * 213 + 107, 160 + 50, 1, 12'hF00);
        cur_row = 0; cur_col = 0;
        write_cell(0, 1, 1);
        lit_check("digit1_seg_b", 213 + 125, 46, 1, 12'hFFF);
        lit_check("digit1_no_seg_a", 213 + 80, 20, 1, 12'h000);
        write_cell(0, 1, 10);
        lit_check("value10_no_glyph", 213 + 80, 20, 1, 12'h000);

        mode = 3'd2;
        lit_check("masked_value10_fill", 213 + 80, 20, 1, 12'hFFF);
        lit_check("masked_filled", 2 * 213 + 80, 160 + 20, 1, 12'hFFF);
        lit_check("masked_empty", 300, 400, 1, 12'h000);
        write_cell(2, 2, 5);
        cur_row = 2; cur_col = 2;
        lit_check("masked_border_on", 430, 325, 1, 12'hF00);
        lit_check("masked_cursor_inner", 530, 400, 1, 12'hFFF);
        x = 10'd430; y = 10'd325;
        pulses(29);
        lit_check("masked_blink_29", 430, 325, 1, 12'hF00);
        pulses(1);
        lit_check("masked_blink_off", 430, 325, 1, 12'hFFF);
        cur_row = 2; cur_col = 1;
        @(negedge clk);
        cur_row = 2; cur_col = 2;
        lit_check("masked_cursor_move", 430, 325, 1, 12'hF00);

        mode = 3'd1;
        cur_row = 0; cur_col = 0;
        @(negedge clk);
        clr = 1; wr_en = 1; wr_row = 2'd1; wr_col = 2'd2; wr_num = 4'd8;
        @(negedge clk);
        clr = 0; wr_en = 0;
        lit_check("clr_beats_write", 2 * 213 + 80, 160 + 20, 1, 12'h000);
        write_cell(3, 1, 8);
        write_cell(1, 3, 8);

        mode = 3'd3;
        lit_check("win_in_grid", 638, 479, 1, 12'h0F0);
        lit_check("win_x_edge", 639, 100, 1, 12'h000);
        lit_check("win_y_out", 100, 500, 1, 12'h000);
        lit_check("win_video_off", 100, 100, 0, 12'h000);
        mode = 3'd4;
        lit_check("lose_black", 100, 100, 1, 12'h000);
        mode = 3'd6;
        lit_check("mode6_black", 100, 100, 1, 12'h000);

        mode = 3'd1;
`ifdef GRID_LINES_EN
        lit_check("grid_line", 213, 100, 1, 12'h444);
        lit_check("grid_x0_not_line", 0, 100, 1, 12'hF00);
`else
        lit_check("no_grid_line", 213, 100, 1, 12'h000);
        lit_check("x0_cursor", 0, 100, 1, 12'hF00);
`endif

        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            wr_en      = ($urandom_range(0, 2) == 0);
            wr_row     = 2'($urandom_range(0, 3));
            wr_col     = 2'($urandom_range(0, 3));
            wr_num     = 4'($urandom_range(0, 15));
            clr        = ($urandom_range(0, 99) == 0);
            frame_tick = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 49) == 0)
                mode = ($urandom_range(0, 3) != 0) ? 3'($urandom_range(1, 2)) : 3'($urandom_range(0, 7));
            if ($urandom_range(0, 199) == 0) begin
                cur_row = 2'($urandom_range(0, 3));
                cur_col = 2'($urandom_range(0, 3));
            end
            x        = 10'($urandom_range(0, 700));
            y        = 10'($urandom_range(0, 520));
            video_on = ($urandom_range(0, 5) != 0);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
